// File: rtl/pc_unit_param.sv
// Fetch-stage program counter: reset, exception, branch and return-stack redirects over a
// sequential increment. Defining PC_RAS_EN builds the return-address stack.
module pc_unit_param #(
  parameter int                ADDR_W       = 32,
  parameter int                INSTR_BYTES  = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'h8),
  parameter int                RAS_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              Branch_taken,
  input  logic [ADDR_W-1:0] BranchAddr,
  input  logic              exc_req,
  input  logic              call_push,
  input  logic              ret_pop,
  output logic [ADDR_W-1:0] buffered_pc,
  output logic              pc_valid,
  output logic              redirect,
  output logic              misalign,
  output logic              ras_empty,
  output logic              ras_underflow
);

  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] LOW_MASK = STEP - ADDR_W'(1);

  typedef enum logic {ST_HOLD, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              redirect_q, redirect_d;
  logic              misalign_q, misalign_d;
  logic              underflow_q, underflow_d;

  logic              run;
  logic [ADDR_W-1:0] seq_pc;
  logic              ras_hit;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_is_empty;
  logic              ras_underflow_cond;
  logic              take;
  logic [ADDR_W-1:0] target;

  assign run    = (state_q == ST_RUN);
  assign seq_pc = pc_q + STEP;

`ifdef PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Circular storage: ptr is the next write slot, so the top lives at ptr-1.
  logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;
  logic [PTR_W-1:0]  top_idx;
  logic              pop_en;
  logic              push_en;
  logic [ADDR_W-1:0] push_val;

  assign top_idx            = ras_ptr_q - PTR_W'(1);
  assign ras_is_empty       = (ras_cnt_q == '0);
  assign ras_top            = ras_mem_q[top_idx];
  assign pop_en             = run & ret_pop & ~exc_req & ~Branch_taken & ~ras_is_empty;
  assign push_en            = run & call_push & ~freeze & ~exc_req & ~pop_en;
  assign push_val           = seq_pc & ~LOW_MASK;
  assign ras_hit            = pop_en;
  assign ras_underflow_cond = run & ret_pop & ras_is_empty;

  always_comb begin
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (run && exc_req) begin
      ras_cnt_d = '0;
    end else if (pop_en) begin
      ras_ptr_d = ras_ptr_q - PTR_W'(1);
      ras_cnt_d = ras_cnt_q - CNT_W'(1);
    end else if (push_en) begin
      ras_ptr_d = ras_ptr_q + PTR_W'(1);
      // When full the write lands on the oldest slot and the count saturates.
      if (ras_cnt_q != CNT_W'(RAS_DEPTH)) begin
        ras_cnt_d = ras_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_en) begin
      ras_mem_q[ras_ptr_q] <= push_val;
    end
  end
`else
  logic unused_ok;

  assign ras_is_empty       = 1'b1;
  assign ras_top            = '0;
  assign ras_hit            = 1'b0;
  assign ras_underflow_cond = 1'b0;
  assign unused_ok          = &{1'b0, call_push, ret_pop, RAS_DEPTH[0]};
`endif

  always_comb begin
    state_d     = ST_RUN;
    pc_d        = pc_q;
    redirect_d  = 1'b0;
    misalign_d  = 1'b0;
    underflow_d = 1'b0;
    take        = 1'b0;
    target      = '0;
    if (run) begin
      if (exc_req) begin
        take   = 1'b1;
        target = EXC_VECTOR;
      end else if (Branch_taken) begin
        take   = 1'b1;
        target = BranchAddr;
      end else if (ras_hit) begin
        take   = 1'b1;
        target = ras_top;
      end
      if (take) begin
        pc_d       = target & ~LOW_MASK;
        redirect_d = 1'b1;
        misalign_d = |(target & LOW_MASK);
      end else if (!freeze) begin
        pc_d = seq_pc;
      end
      underflow_d = ras_underflow_cond;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      pc_q        <= RESET_VECTOR;
      redirect_q  <= 1'b0;
      misalign_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      redirect_q  <= redirect_d;
      misalign_q  <= misalign_d;
      underflow_q <= underflow_d;
    end
  end

  assign buffered_pc   = pc_q;
  assign pc_valid      = run;
  assign redirect      = redirect_q;
  assign misalign      = misalign_q;
  assign ras_empty     = ras_is_empty;
  assign ras_underflow = underflow_q;

endmodule

// File: tb/tb_pc_unit_param.sv
// Self-checking bench for pc_unit_param: vector table, hand sequences (8-bit wrap, RAS when
// PC_RAS_EN is defined) and randomized stimulus against a behavioural model.
module tb_pc_unit_param;

  logic        clk = 1'b0;
  logic        rst, freeze, br, exc, push, pop;
  logic [31:0] addr;
  logic [31:0] pc;
  logic        valid, redir, mis, empty, unf;

  logic        rst8;
  logic [7:0]  pc8;
  logic        valid8, redir8, mis8, empty8, unf8;
  logic        zero1 = 1'b0;
  logic [7:0]  zero8 = 8'h0;

  int checks = 0;
  int errors = 0;

`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  pc_unit_param u_dut (
    .clk(clk), .rst(rst), .freeze(freeze), .Branch_taken(br), .BranchAddr(addr),
    .exc_req(exc), .call_push(push), .ret_pop(pop), .buffered_pc(pc), .pc_valid(valid),
    .redirect(redir), .misalign(mis), .ras_empty(empty), .ras_underflow(unf)
  );

  pc_unit_param #(.ADDR_W(8), .RESET_VECTOR(8'hF0)) u_dut8 (
    .clk(clk), .rst(rst8), .freeze(zero1), .Branch_taken(zero1), .BranchAddr(zero8),
    .exc_req(zero1), .call_push(zero1), .ret_pop(zero1), .buffered_pc(pc8), .pc_valid(valid8),
    .redirect(redir8), .misalign(mis8), .ras_empty(empty8), .ras_underflow(unf8)
  );

  typedef struct {
    logic        rst, frz, br;
    logic [31:0] addr;
    logic        exc;
    logic [31:0] e_pc;
    logic        e_valid, e_redir, e_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic f, logic b, logic [31:0] a, logic e,
                              logic [31:0] epc, logic ev, logic er, logic em);
    vec_t v;
    v.rst = r; v.frz = f; v.br = b; v.addr = a; v.exc = e;
    v.e_pc = epc; v.e_valid = ev; v.e_redir = er; v.e_mis = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic b, input logic [31:0] a,
                       input logic e, input logic pu, input logic po);
    rst = r; freeze = f; br = b; addr = a; exc = e; push = pu; pop = po;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: architectural PC plus a queue-based return stack.
  logic [31:0] m_pc;
  bit          m_run, m_redir, m_mis, m_unf;
  logic [31:0] m_ras[$];

  task automatic model_step(input logic r, input logic f, input logic b, input logic [31:0] a,
                            input logic e, input logic pu, input logic po);
    logic [31:0] old_pc, tgt;
    bit taken, popped, was_empty;
    old_pc = m_pc; taken = 0; popped = 0; tgt = 0;
    was_empty = (m_ras.size() == 0);
    m_redir = 0; m_mis = 0; m_unf = 0;
    if (r) begin
      m_pc = 0; m_run = 0; m_ras.delete();
    end else if (!m_run) begin
      m_run = 1;
    end else begin
      if (e) begin
        taken = 1; tgt = 32'h8;
        if (RAS_ON) m_ras.delete();
      end else if (b) begin
        taken = 1; tgt = a;
      end else if (RAS_ON && po && !was_empty) begin
        taken = 1; popped = 1; tgt = m_ras.pop_back();
      end
      if (taken) begin
        m_pc = tgt - (tgt % 4); m_redir = 1; m_mis = (tgt % 4) != 0;
      end else if (!f) begin
        m_pc = old_pc + 4;
      end
      if (RAS_ON && pu && !f && !e && !popped) begin
        m_ras.push_back(old_pc + 4);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
      m_unf = RAS_ON && po && was_empty;
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);
    rst8 = 1'b1;

    // Tests 1-4 plus freeze-hold and reset-overrides-redirect.
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        0, 32'h0,   1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        0, 32'h4,   1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        0, 32'h8,   1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,        0, 32'h8,   1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h100,  0, 32'h100, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,        0, 32'h104, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h40,   0, 32'h40,  1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 32'h300,  1, 32'h8,   1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0,        0, 32'hC,   1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h203,  0, 32'h200, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0,        0, 32'h204, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,        0, 32'h204, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0,        1, 32'h8,   1, 1, 0));
    vecs.push_back(mk(1, 0, 1, 32'h500,  1, 32'h0,   0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        0, 32'h0,   1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0,        0, 32'h4,   1, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].frz, vecs[i].br, vecs[i].addr, vecs[i].exc, 0, 0);
      tick();
      check($sformatf("vec%0d.pc", i), pc, vecs[i].e_pc);
      check($sformatf("vec%0d.valid", i), 32'(valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d.redirect", i), 32'(redir), 32'(vecs[i].e_redir));
      check($sformatf("vec%0d.misalign", i), 32'(mis), 32'(vecs[i].e_mis));
      check($sformatf("vec%0d.ras_empty", i), 32'(empty), 32'h1);
      check($sformatf("vec%0d.underflow", i), 32'(unf), 32'h0);
      $display("vec %0d: pc=0x%0h valid=%0d redirect=%0d misalign=%0d", i, pc, valid, redir, mis);
    end

    // 8-bit instance: F0 held for one cycle, then increments wrap FC -> 00 with no redirect.
    rst8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("wrap8.pc%0d", i), 32'(pc8), 32'((i == 0) ? 8'hF0 : 8'(8'hF0 + 8'(4 * i))));
      $display("wrap8 step %0d: pc=0x%0h redirect=%0d", i, pc8, redir8);
    end
    check("wrap8.redirect", 32'(redir8), 32'h0);
    check("wrap8.valid", 32'(valid8), 32'h1);
    check("wrap8.misalign", 32'(mis8), 32'h0);

`ifdef PC_RAS_EN
    // Five call-branches then five returns on a depth-4 stack.
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 32'h10, 0, 0, 0); tick();
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 1, (i == 5) ? 32'h100 : 32'(16 * (i + 1)), 0, 1, 0);
      tick();
      $display("ras push %0d: pc=0x%0h ras_empty=%0d", i, pc, empty);
    end
    check("ras.after_push_pc", pc, 32'h100);
    check("ras.after_push_empty", 32'(empty), 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1); tick();
      check($sformatf("ras.pop%0d.pc", i), pc, 32'h54 - 32'(16 * i));
      check($sformatf("ras.pop%0d.redirect", i), 32'(redir), 32'h1);
      $display("ras pop %0d: pc=0x%0h redirect=%0d", i, pc, redir);
    end
    check("ras.empty_after_4", 32'(empty), 32'h1);
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    check("ras.unf_pc", pc, 32'h28);
    check("ras.unf_flag", 32'(unf), 32'h1);
    check("ras.unf_redirect", 32'(redir), 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    check("ras.unf_clear", 32'(unf), 32'h0);
    $display("ras underflow seq: pc=0x%0h", pc);
`endif

    // Randomized run against the behavioural model.
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    model_step(1, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 500; n++) begin
      logic r, f, b, e, pu, po;
      logic [31:0] a;
      r  = ($urandom_range(0, 49) == 0);
      f  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 5) == 0);
      e  = ($urandom_range(0, 24) == 0);
      pu = ($urandom_range(0, 3) == 0);
      po = !pu && ($urandom_range(0, 4) == 0);
      a  = $urandom();
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      drive(r, f, b, a, e, pu, po);
      tick();
      model_step(r, f, b, a, e, pu, po);
      check($sformatf("rnd%0d.pc", n), pc, m_pc);
      check($sformatf("rnd%0d.valid", n), 32'(valid), 32'(m_run));
      check($sformatf("rnd%0d.redirect", n), 32'(redir), 32'(m_redir));
      check($sformatf("rnd%0d.misalign", n), 32'(mis), 32'(m_mis));
      check($sformatf("rnd%0d.ras_empty", n), 32'(empty), 32'(!RAS_ON || m_ras.size() == 0));
      check($sformatf("rnd%0d.underflow", n), 32'(unf), 32'(m_unf));
      $display("rnd %0d: in rst=%0d frz=%0d br=%0d exc=%0d push=%0d pop=%0d -> pc=0x%0h model=0x%0h",
               n, r, f, b, e, pu, po, pc, m_pc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
